// File: rtl/crc_frame_serializer.sv
// Parallel-to-serial feeder for a serial CRC engine: shifts framed words out LSB first and
// holds off the next frame until the engine's valid window has closed.
module crc_frame_serializer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  data,
  output logic                  active,
  input  logic                  crc_valid,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned BitW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_WIDTH - 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StShift, StWaitValid, StDrain} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic [DATA_WIDTH-1:0] hold_data_q;
  logic                  cur_last_q;
  logic                  hold_full_q;
  logic                  hold_last_q;
  logic                  last_acc_q;
  logic [BitW-1:0]       bit_cnt_q;
  logic [TmoW-1:0]       tmo_cnt_q;
  logic                  data_q;
  logic                  active_q;
  logic                  err_q;
  logic                  accept;

  assign in_ready = !hold_full_q && !last_acc_q && (state_q == StIdle || state_q == StShift);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != StIdle);
  assign data     = data_q;
  assign active   = active_q;
  assign err      = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      hold_data_q <= '0;
      cur_last_q  <= 1'b0;
      hold_full_q <= 1'b0;
      hold_last_q <= 1'b0;
      last_acc_q  <= 1'b0;
      bit_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      data_q      <= 1'b0;
      active_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            shreg_q    <= in_data;
            cur_last_q <= in_last;
            last_acc_q <= in_last;
            bit_cnt_q  <= '0;
            data_q     <= in_data[0];
            active_q   <= 1'b1;
            err_q      <= 1'b0;
            state_q    <= StShift;
          end
        end
        StShift: begin
          if (bit_cnt_q != LastBit) begin
            bit_cnt_q <= bit_cnt_q + BitW'(1);
            shreg_q   <= shreg_q >> 1;
            data_q    <= shreg_q[1];
            if (accept) begin
              hold_data_q <= in_data;
              hold_last_q <= in_last;
              hold_full_q <= 1'b1;
              if (in_last) last_acc_q <= 1'b1;
            end
          end else if (hold_full_q) begin
            shreg_q     <= hold_data_q;
            cur_last_q  <= hold_last_q;
            data_q      <= hold_data_q[0];
            bit_cnt_q   <= '0;
            hold_full_q <= 1'b0;
          end else if (accept) begin
            // A word arriving during the final bit bypasses the holding register.
            shreg_q    <= in_data;
            cur_last_q <= in_last;
            data_q     <= in_data[0];
            bit_cnt_q  <= '0;
            if (in_last) last_acc_q <= 1'b1;
          end else begin
            active_q   <= 1'b0;
            data_q     <= 1'b0;
            tmo_cnt_q  <= '0;
            last_acc_q <= 1'b0;
            state_q    <= StWaitValid;
            if (!cur_last_q) err_q <= 1'b1;
          end
        end
        StWaitValid: begin
          if (crc_valid) begin
            state_q <= StDrain;
          end else if (tmo_cnt_q == TmoLast) begin
            err_q   <= 1'b1;
            state_q <= StIdle;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
          end
        end
        StDrain: begin
          if (!crc_valid) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/crc_frame_serializer.md
# crc_frame_serializer

Upstream feeder for the serial CRC engine: accepts parallel bytes over a valid/ready handshake, grouped into frames by a last flag, and drives the engine's serial `data`/`active` inputs LSB first with no gaps inside a frame. After the last bit it holds off new frames until the engine's `valid` window has completed, so frames never overlap the CRC readout. A one-entry holding register lets the next byte be accepted while the current byte is shifting.

## Interface
- `DATA_WIDTH`, 8: bits per input word; matches the CRC engine's `lfsr_width`.
- `TIMEOUT`, 16: maximum cycles to wait for `crc_valid` to rise after a frame ends.
- `clk`  in  1  rising-edge clock, the one clock of the block.
- `rst`  in  1  asynchronous, active-low reset.
- `in_data`  in  DATA_WIDTH  word to serialize.
- `in_valid`  in  1  `in_data`/`in_last` are valid.
- `in_last`  in  1  word is the final word of the frame.
- `in_ready`  out  1  block accepts a word this cycle.
- `data`  out  1  serial bit to the CRC engine, LSB first.
- `active`  out  1  frame in progress; connects to the engine's `active`.
- `crc_valid`  in  1  the engine's `valid` output.
- `busy`  out  1  frame shifting or CRC readout pending.
- `err`  out  1  sticky per frame: underrun or timeout.

## Operation
- A word is accepted on a rising edge with `in_valid & in_ready`. `in_ready` = holding register empty & state is IDLE or SHIFT & the last word of the current frame has not yet been accepted. It is combinational from registers.
- States:
  - IDLE: an accepted word loads the shift register directly and moves to SHIFT. `err` clears on this load.
  - SHIFT: one bit per cycle. The bit counter runs 0..DATA_WIDTH-1.
    - When the last bit of a word is on `data`: if the holding register is full, it loads into the shift register on the next edge and shifting continues with no gap.
    - Else, if the word was marked last, go to WAIT_VALID.
    - Else (underrun), go to WAIT_VALID and set `err`. The frame ends short.
  - WAIT_VALID: the timeout counter increments each cycle. When `crc_valid` is high, go to DRAIN. If the counter reaches TIMEOUT, set `err` and go to IDLE.
  - DRAIN: stay while `crc_valid` is high. On the first cycle it is low, go to IDLE.
- In SHIFT, a word arriving while the holding register is empty is stored there with its last flag.
- `busy` = state is not IDLE.
- Counter widths are `$clog2(DATA_WIDTH)` and `$clog2(TIMEOUT+1)`, and they do not wrap. The bit counter resets to 0 on every word load.

## Timing
- Reset values: `data`=0, `active`=0, `busy`=0, `err`=0, state IDLE, holding register empty, counters 0. `in_ready`=1 once reset deasserts.
- Reset asserted mid-frame immediately forces all of the above. The partial frame is discarded and not resumed.
- `data`/`active` are registered. For a word accepted at edge k from IDLE, `active`=1 and `data`=bit0 after edge k, and bit i is presented after edge k+i.
  - For a last word, `active`=0 and `data`=0 after edge k+DATA_WIDTH.
  - An N-word frame holds `active` high for exactly N·DATA_WIDTH cycles.
- The holding register accepts a word no later than the cycle before a word's last bit. A word accepted in that same cycle still chains with no gap.
- `in_valid` with `in_ready`=0: the block does not sample the input. The source must hold it.
- If `crc_valid` is already high in the first WAIT_VALID cycle, go to DRAIN the same cycle.
- The next frame's first accept is possible in the cycle after `crc_valid` falls, when the state returns to IDLE.

## Test plan
- Single word 0xA5, last=1, with a CRC model that raises valid 2 cycles after `active` falls for 8 cycles:
  - `data` = 1,0,1,0,0,1,0,1.
  - `active` is high for exactly 8 cycles.
  - `in_ready`=0 from accept until `crc_valid` falls.
  - `busy` then drops and `err`=0.
- Two-word frame 0x01 then 0x80 (last), second word offered during bit 3 of the first:
  - `active` is high for 16 contiguous cycles.
  - `data` is 1 followed by 14 zeros then 1.
- Underrun: word 0x3C with last=0 and no second word:
  - `active` drops after 8 cycles.
  - `err`=1, which clears when the next frame's first word loads.
- Timeout: frame 0xFF last=1 with `crc_valid` tied low:
  - `busy` falls and `err`=1 exactly TIMEOUT cycles after entering WAIT_VALID.
  - `in_ready` returns to 1.
- Reset mid-shift at bit 4 of 0x5A:
  - `data`/`active`/`busy`/`err` are 0 immediately.
  - After release, frame 0x0F shifts cleanly as 1,1,1,1,0,0,0,0.
- Backpressure: a third word 0x77 held valid while the holding register is full:
  - It is accepted only once the holding register empties.
  - It appears intact as 1,1,1,0,1,1,1,0.
